// File: rtl/snake_engine.sv
// Snake game-state engine: body shift register, move timing, collisions and registered pixel class for vga_wrapper.
// Optional build macro SNAKE_WRAP_EN: head wraps around the grid edges and no wall cells exist.
module snake_engine #(
   parameter int MAX_LEN     = 8,
   parameter int MOVE_FRAMES = 15,
   parameter int CELL_LOG2   = 4,
   parameter int GRID_W      = 40,
   parameter int GRID_H      = 30,
   parameter int START_X     = 20,
   parameter int START_Y     = 15
) (
   input  logic       clock_25,
   input  logic       reset,
   input  logic [9:0] X,
   input  logic [9:0] Y,
   input  logic [3:0] dir_btn,
   input  logic       start,
   output logic [1:0] color_data,
   output logic       game_enable,
   output logic       game_over,
   output logic [5:0] head_x,
   output logic [4:0] head_y
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_OVER = 2'd2} state_t;

   localparam logic [1:0] D_UP = 2'd0, D_DOWN = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3;
   localparam int FW = (MOVE_FRAMES > 1) ? $clog2(MOVE_FRAMES) : 1;
`ifdef SNAKE_WRAP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   state_t        state_q, state_d;
   logic [5:0]    seg_x_q [MAX_LEN];
   logic [5:0]    seg_x_d [MAX_LEN];
   logic [4:0]    seg_y_q [MAX_LEN];
   logic [4:0]    seg_y_d [MAX_LEN];
   logic [1:0]    dir_q, dir_d, pend_q, pend_d;
   logic [FW-1:0] cnt_q, cnt_d;
   logic [1:0]    color_q, color_d;
   logic          enable_q, enable_d, over_q, over_d;

   logic          frame_tick_s, restart_s, wall_hit_s, self_hit_s;
   logic [1:0]    btn_dir_s;
   logic [5:0]    next_x_s;
   logic [4:0]    next_y_s;
   logic [9:0]    cell_x_s, cell_y_s;
   logic          hit_head_s, hit_body_s, hit_border_s, in_screen_s;

   assign frame_tick_s = (X == 10'd0) && (Y == 10'd480);
   assign color_data   = color_q;
   assign game_enable  = enable_q;
   assign game_over    = over_q;
   assign head_x       = seg_x_q[0];
   assign head_y       = seg_y_q[0];

   always_comb begin
      if (dir_btn[3])      btn_dir_s = D_UP;
      else if (dir_btn[2]) btn_dir_s = D_DOWN;
      else if (dir_btn[1]) btn_dir_s = D_LEFT;
      else                 btn_dir_s = D_RIGHT;
   end

   // Candidate head cell and its collisions, from the pending direction as registered.
   always_comb begin
      next_x_s = seg_x_q[0];
      next_y_s = seg_y_q[0];
      case (pend_q)
         D_UP: begin
            if (WRAP_EN && seg_y_q[0] == 5'd0) next_y_s = 5'(GRID_H - 1);
            else                               next_y_s = seg_y_q[0] - 5'd1;
         end
         D_DOWN: begin
            if (WRAP_EN && seg_y_q[0] == 5'(GRID_H - 1)) next_y_s = 5'd0;
            else                                         next_y_s = seg_y_q[0] + 5'd1;
         end
         D_LEFT: begin
            if (WRAP_EN && seg_x_q[0] == 6'd0) next_x_s = 6'(GRID_W - 1);
            else                               next_x_s = seg_x_q[0] - 6'd1;
         end
         default: begin
            if (WRAP_EN && seg_x_q[0] == 6'(GRID_W - 1)) next_x_s = 6'd0;
            else                                         next_x_s = seg_x_q[0] + 6'd1;
         end
      endcase
      wall_hit_s = !WRAP_EN && (next_x_s == 6'd0 || next_x_s == 6'(GRID_W - 1) ||
                                next_y_s == 5'd0 || next_y_s == 5'(GRID_H - 1));
      self_hit_s = 1'b0;
      for (int i = 0; i < MAX_LEN - 1; i++) begin
         self_hit_s = self_hit_s | ((next_x_s == seg_x_q[i]) && (next_y_s == seg_y_q[i]));
      end
   end

   // Game FSM, frame counter, body shift and direction bookkeeping.
   always_comb begin
      state_d   = state_q;
      seg_x_d   = seg_x_q;
      seg_y_d   = seg_y_q;
      dir_d     = dir_q;
      cnt_d     = cnt_q;
      restart_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               cnt_d   = {FW{1'b0}};
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (frame_tick_s && cnt_q == FW'(MOVE_FRAMES - 1)) begin
               cnt_d = {FW{1'b0}};
               if (wall_hit_s || self_hit_s) begin
                  state_d = S_OVER;
               end else begin
                  for (int i = MAX_LEN - 1; i > 0; i--) begin
                     seg_x_d[i] = seg_x_q[i-1];
                     seg_y_d[i] = seg_y_q[i-1];
                  end
                  seg_x_d[0] = next_x_s;
                  seg_y_d[0] = next_y_s;
                  dir_d      = pend_q;
               end
            end else if (frame_tick_s) begin
               cnt_d = cnt_q + FW'(1);
            end else begin
               cnt_d = cnt_q;
            end
         end
         S_OVER: begin
            if (start) begin
               state_d   = S_IDLE;
               restart_s = 1'b1;
               cnt_d     = {FW{1'b0}};
               dir_d     = D_RIGHT;
               for (int i = 0; i < MAX_LEN; i++) begin
                  seg_x_d[i] = 6'(START_X - i);
                  seg_y_d[i] = 5'(START_Y);
               end
            end else begin
               state_d = S_OVER;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Reversal is judged against the direction in force after this edge, so a move cannot sneak one in.
      if (restart_s)                                        pend_d = D_RIGHT;
      else if ((|dir_btn) && (btn_dir_s != (dir_d ^ 2'b01))) pend_d = btn_dir_s;
      else                                                  pend_d = pend_q;
   end

   // Pixel classification for the raster position currently presented.
   always_comb begin
      cell_x_s     = X >> CELL_LOG2;
      cell_y_s     = Y >> CELL_LOG2;
      in_screen_s  = (X < 10'd640) && (Y < 10'd480);
      hit_head_s   = (cell_x_s == {4'd0, seg_x_q[0]}) && (cell_y_s == {5'd0, seg_y_q[0]});
      hit_body_s   = 1'b0;
      for (int i = 1; i < MAX_LEN; i++) begin
         hit_body_s = hit_body_s |
                      ((cell_x_s == {4'd0, seg_x_q[i]}) && (cell_y_s == {5'd0, seg_y_q[i]}));
      end
      hit_border_s = !WRAP_EN && (cell_x_s == 10'd0 || cell_x_s == 10'(GRID_W - 1) ||
                                  cell_y_s == 10'd0 || cell_y_s == 10'(GRID_H - 1));
      enable_d     = (state_q != S_IDLE);
      over_d       = (state_q == S_OVER);
      if (!enable_d || !in_screen_s) color_d = 2'b00;
      else if (hit_head_s)           color_d = 2'b01;
      else if (hit_body_s)           color_d = 2'b10;
      else if (hit_border_s)         color_d = 2'b11;
      else                           color_d = 2'b00;
   end

   // State and output registers.
   always_ff @(posedge clock_25 or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         dir_q    <= D_RIGHT;
         pend_q   <= D_RIGHT;
         cnt_q    <= {FW{1'b0}};
         color_q  <= 2'b00;
         enable_q <= 1'b0;
         over_q   <= 1'b0;
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_q[i] <= 6'(START_X - i);
            seg_y_q[i] <= 5'(START_Y);
         end
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         pend_q   <= pend_d;
         cnt_q    <= cnt_d;
         color_q  <= color_d;
         enable_q <= enable_d;
         over_q   <= over_d;
         seg_x_q  <= seg_x_d;
         seg_y_q  <= seg_y_d;
      end
   end

endmodule

// File: doc/snake_engine.md
# snake_engine

Game-state engine that sits directly upstream of the VGA output stage. It holds the snake's head and body as a shift register of grid cells and advances it once every `MOVE_FRAMES` video frames under button control. It detects wall and self collisions, and from the raster coordinates `X`/`Y` it produces the registered `color_data` and `game_enable` that drive `vga_wrapper`, replacing the tied-off constants.

## Interface
- `MAX_LEN`, 8: number of segments; segment 0 is the head.
- `MOVE_FRAMES`, 15: frames between moves (≥1).
- `CELL_LOG2`, 4: cell size is 2^CELL_LOG2 pixels.
- `GRID_W`, 40: grid width in cells.
- `GRID_H`, 30: grid height in cells.
- `START_X`, 20: initial head cell x (≥ MAX_LEN).
- `START_Y`, 15: initial head cell y.

Ports:
- `clock_25`  in  1: 25 MHz pixel clock; the only clock.
- `reset`  in  1: asynchronous, active-high reset.
- `X`  in  10: raster column from `vga_wrapper`.
- `Y`  in  10: raster row from `vga_wrapper`.
- `dir_btn`  in  4: {up,down,left,right}, active-high, already synchronised.
- `start`  in  1: one-cycle start/restart pulse.
- `color_data`  out  2: pixel class; 00 background, 01 head, 10 body, 11 wall.
- `game_enable`  out  1: high in RUN and OVER.
- `game_over`  out  1: high in OVER.
- `head_x`  out  6: head cell x.
- `head_y`  out  5: head cell y.

## Operation
- States: IDLE, RUN, OVER.
  - IDLE: `start` → RUN; the frame counter clears.
  - RUN: collision on a move → OVER.
  - OVER: `start` → body re-initialised, then IDLE.
  - `start` in RUN is ignored.
- Init (reset or restart from OVER):
  - Segment i = (START_X−i, START_Y); direction = right; pending direction = right.
  - Frame counter = 0.
- Frame tick: one-cycle pulse when X==0 && Y==480. The frame counter increments only in RUN. At MOVE_FRAMES−1 it wraps to 0 and a move occurs in the same cycle.
- Direction input:
  - Every cycle, `dir_btn` is reduced by priority up>down>left>right.
  - The result is written to the pending direction unless it is the reverse of the applied direction.
  - All-zero input keeps the pending direction.
  - Pending becomes applied at each move.
- Move:
  - next_head = head + step(pending).
  - Segments shift: seg[i] ← seg[i−1]; seg[0] ← next_head.
  - All segments update in one cycle.
- Collision (evaluated on next_head before the shift):
  - Wall: next_head in a border cell (x==0, x==GRID_W−1, y==0, y==GRID_H−1).
  - Self: next_head equals any seg[0..MAX_LEN−2]. The tail segment vacates and is excluded.
  - On collision there is no shift; the state goes to OVER and the snake freezes.
- Pixel classification:
  - cx = X>>CELL_LOG2, cy = Y>>CELL_LOG2.
  - Outside 640×480 → 00.
  - Priority: head 01 > body 10 > border 11 > 00.
- `color_data` is 00 when `game_enable`=0.

## Timing
- Reset values:
  - `color_data`=00, `game_enable`=0, `game_over`=0.
  - `head_x`=START_X, `head_y`=START_Y; state IDLE.
- `color_data` is registered: it reflects the X/Y presented on the previous clock edge (1-cycle latency). `vga_wrapper` compensates.
- `game_enable`/`game_over` rise or fall on the clock edge after the state transition.
- `start` and the move tick in the same cycle while in RUN: the move proceeds and `start` is ignored.
- Button change and a move in the same cycle: the move uses pending as registered before that edge.
- Reset asserted mid-move: all registers return to init values immediately; no partial shift survives.
- Coordinate arithmetic:
  - Width is 6 bits for x and 5 bits for y.
  - Without wrap, the border check precedes any overflow.

## Configuration
- `SNAKE_WRAP_EN`:
  - Defined: border cells are neither drawn nor colliding. The head wraps modulo GRID_W/GRID_H (x 0↔GRID_W−1, y 0↔GRID_H−1). Only self-collision ends the game, and the border class 11 is never output.
  - Undefined: wall collision and the 11 border class are active, as above.

## Test plan
- Reset, then `start`, no buttons, MOVE_FRAMES=2: after 2 frame ticks `head_x`=21; after 4 ticks `head_x`=22, `head_y`=15.
- In RUN, heading right, assert left then down in the same frame: left is rejected and down is taken. Next move gives `head_y`=16, `head_x` unchanged.
- Head at x=38 heading right, no wrap: the next move raises `game_over`=1, `head_x` stays 38, and `game_enable` stays 1.
- Same scenario with `SNAKE_WRAP_EN`: `head_x` goes 38→39→0 with `game_over`=0.
- Steer down, left, up into own body: `game_over` asserts on the move whose next_head equals seg[3].
- Raster sweep with X=320,Y=240 (cell 20,15) at init: `color_data`=01 one cycle later. X=304 → 10; X=0 → 11; X=700 → 00.
- Reset asserted during RUN mid-frame: outputs return to reset values in the same cycle, asynchronously.
